// File: rtl/proc_pkg.sv
// Shared processor-datapath definitions: write-port operation codes and default data width.
package proc_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_ADD   = 2'b01,
      OP_INVAL = 2'b10,
      OP_RSVD  = 2'b11
   } wr_op_e;

endpackage

// File: rtl/regbank_read_mux.sv
// One combinational read port of the register bank: selects a stored entry and
// substitutes the in-flight write result when the write targets the same address.
module regbank_read_mux #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0]                rd_addr_i,
   input  logic [DEPTH-1:0][WIDTH-1:0]  data_q_i,
   input  logic [DEPTH-1:0]             valid_q_i,
   input  logic                         byp_en_i,
   input  logic [AW-1:0]                byp_addr_i,
   input  logic [WIDTH-1:0]             byp_data_i,
   input  logic                         byp_valid_i,
   output logic [WIDTH-1:0]             rd_data_o,
   output logic                         rd_valid_o
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      rd_data_o  = '0;
      rd_valid_o = 1'b0;
      // Addresses >= DEPTH match no entry and fall through to the zero default.
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr_i == AW'(i)) begin
            rd_data_o  = data_q_i[i];
            rd_valid_o = valid_q_i[i];
         end
      end
      if (byp_en_i && (byp_addr_i == rd_addr_i)) begin
         rd_data_o  = byp_data_i;
         rd_valid_o = byp_valid_i;
      end
   end

endmodule

// File: rtl/register_bank.sv
// Multi-entry register bank: one synchronous LOAD/ADD/INVAL write port, two bypassed
// combinational operand ports, and a one-cycle registered bus read port.
module register_bank
   import proc_pkg::*;
#(
   parameter int  WIDTH = DATA_W,
   parameter int  DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [1:0]        wr_op,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [AW-1:0]     rd_a_addr,
   output logic [WIDTH-1:0]  rd_a_data,
   output logic              rd_a_valid,
   input  logic [AW-1:0]     rd_b_addr,
   output logic [WIDTH-1:0]  rd_b_data,
   output logic              rd_b_valid,
   input  logic              bus_en,
   input  logic [AW-1:0]     bus_addr,
   output logic [WIDTH-1:0]  bus_data,
   output logic              bus_valid
);

   logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [WIDTH-1:0]            bus_data_q, bus_data_d;
   logic                        bus_valid_q, bus_valid_d;

   logic [WIDTH-1:0]            wr_old_data, wr_new_data;
   logic                        wr_old_valid, wr_new_valid;
   logic                        wr_in_range, wr_commit;

   // Post-write value of the addressed entry; shared by storage update, bypass and bus.
   always_comb begin
      wr_old_data  = '0;
      wr_old_valid = 1'b0;
      wr_in_range  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_addr == AW'(i)) begin
            wr_old_data  = data_q[i];
            wr_old_valid = valid_q[i];
            wr_in_range  = 1'b1;
         end
      end
      case (wr_op)
         OP_LOAD: begin
            wr_new_data  = wr_data;
            wr_new_valid = 1'b1;
         end
         OP_ADD: begin
            wr_new_data  = wr_old_data + wr_data;
            wr_new_valid = 1'b1;
         end
         OP_INVAL: begin
            wr_new_data  = wr_old_data;
            wr_new_valid = 1'b0;
         end
         default: begin
            wr_new_data  = wr_old_data;
            wr_new_valid = wr_old_valid;
         end
      endcase
   end

   // A write lands only outside reset and clear, in range, and with a defined opcode.
   assign wr_commit = rst && wr_en && !clr && wr_in_range && (wr_op != OP_RSVD);

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clr) begin
         data_d  = '0;
         valid_d = '0;
      end else if (wr_commit) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == AW'(i)) begin
               data_d[i]  = wr_new_data;
               valid_d[i] = wr_new_valid;
            end
         end
      end
   end

   // The bus samples the post-edge contents, so a same-cycle write or clear is visible.
   always_comb begin
      bus_data_d  = '0;
      bus_valid_d = 1'b0;
      if (bus_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bus_addr == AW'(i)) begin
               bus_data_d  = data_d[i];
               bus_valid_d = valid_d[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: the storage array is reset too, because entries must read back as zero after reset.
      if (!rst) begin
         data_q      <= '0;
         valid_q     <= '0;
         bus_data_q  <= '0;
         bus_valid_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         data_q      <= data_d;
         valid_q     <= valid_d;
         bus_data_q  <= bus_data_d;
         bus_valid_q <= bus_valid_d;
      end
   end

   assign bus_data  = bus_data_q;
   assign bus_valid = bus_valid_q;

   regbank_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_a (
      .rd_addr_i   (rd_a_addr),
      .data_q_i    (data_q),
      .valid_q_i   (valid_q),
      .byp_en_i    (wr_commit),
      .byp_addr_i  (wr_addr),
      .byp_data_i  (wr_new_data),
      .byp_valid_i (wr_new_valid),
      .rd_data_o   (rd_a_data),
      .rd_valid_o  (rd_a_valid)
   );

   regbank_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_b (
      .rd_addr_i   (rd_b_addr),
      .data_q_i    (data_q),
      .valid_q_i   (valid_q),
      .byp_en_i    (wr_commit),
      .byp_addr_i  (wr_addr),
      .byp_data_i  (wr_new_data),
      .byp_valid_i (wr_new_valid),
      .rd_data_o   (rd_b_data),
      .rd_valid_o  (rd_b_valid)
   );

endmodule

// File: tb/tb_register_bank.sv
// Randomised bench for register_bank (WIDTH=16, DEPTH=6) against an array-based
// reference of the bank contents, plus directed reset, bypass, wrap, clear and range cases.
module tb_register_bank;

   localparam int W  = 16;
   localparam int D  = 6;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic          wr_en;
   logic [1:0]    wr_op;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [AW-1:0] rd_a_addr, rd_b_addr, bus_addr;
   logic [W-1:0]  rd_a_data, rd_b_data, bus_data;
   logic          rd_a_valid, rd_b_valid, bus_en, bus_valid;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] mdl_data  [D];
   logic         mdl_valid [D];

   register_bank #(.WIDTH(W), .DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .wr_en      (wr_en),
      .wr_op      (wr_op),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_a_addr  (rd_a_addr),
      .rd_a_data  (rd_a_data),
      .rd_a_valid (rd_a_valid),
      .rd_b_addr  (rd_b_addr),
      .rd_b_data  (rd_b_data),
      .rd_b_valid (rd_b_valid),
      .bus_en     (bus_en),
      .bus_addr   (bus_addr),
      .bus_data   (bus_data),
      .bus_valid  (bus_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Value entry a would hold after this cycle's write (ignoring clear), zero if out of range.
   task automatic post(input int a, output logic [W-1:0] d, output logic v);
      if (a >= D) begin
         d = '0;
         v = 1'b0;
      end else begin
         d = mdl_data[a];
         v = mdl_valid[a];
         if (wr_en && !clr && (int'(wr_addr) == a)) begin
            case (int'(wr_op))
               0: begin d = wr_data; v = 1'b1; end
               1: begin d = d + wr_data; v = 1'b1; end
               2: v = 1'b0;
               default: ;
            endcase
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < D; i++) begin
         mdl_data[i]  = '0;
         mdl_valid[i] = 1'b0;
      end
   endtask

   task automatic idle();
      clr = 0; wr_en = 0; wr_op = 0; wr_addr = 0; wr_data = 0;
      rd_a_addr = 0; rd_b_addr = 0; bus_en = 0; bus_addr = 0;
   endtask

   // Entered at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic cycle(input string tag);
      logic [W-1:0] ed, wd;
      logic         ev, wv;
      #3;
      post(int'(rd_a_addr), ed, ev);
      check({tag, "_rda_d"}, rd_a_data, ed);
      check({tag, "_rda_v"}, rd_a_valid, ev);
      post(int'(rd_b_addr), ed, ev);
      check({tag, "_rdb_d"}, rd_b_data, ed);
      check({tag, "_rdb_v"}, rd_b_valid, ev);
      @(posedge clk);
      if (clr) begin
         model_reset();
      end else if (int'(wr_addr) < D) begin
         post(int'(wr_addr), wd, wv);
         mdl_data[wr_addr]  = wd;
         mdl_valid[wr_addr] = wv;
      end
      ed = '0;
      ev = 1'b0;
      if (bus_en && int'(bus_addr) < D) begin
         ed = mdl_data[bus_addr];
         ev = mdl_valid[bus_addr];
      end
      #1;
      check({tag, "_bus_d"}, bus_data, ed);
      check({tag, "_bus_v"}, bus_valid, ev);
   endtask

   task automatic write(input int op, input int a, input logic [W-1:0] d, input string tag);
      wr_en = 1; wr_op = 2'(op); wr_addr = AW'(a); wr_data = d;
      cycle(tag);
      wr_en = 0;
   endtask

   initial begin
      idle();
      model_reset();
      rst = 0;
      #12;
      for (int a = 0; a < 8; a++) begin
         rd_a_addr = AW'(a);
         rd_b_addr = AW'(7 - a);
         #1;
         check("rst_rda_d", rd_a_data, 0);
         check("rst_rda_v", rd_a_valid, 0);
         check("rst_rdb_d", rd_b_data, 0);
         check("rst_rdb_v", rd_b_valid, 0);
      end
      check("rst_bus_d", bus_data, 0);
      check("rst_bus_v", bus_valid, 0);
      idle();
      rst = 1;
      @(posedge clk); #1;
      for (int a = 0; a < 8; a++) begin
         bus_en = 1; bus_addr = AW'(a); rd_a_addr = AW'(a); rd_b_addr = AW'(a);
         cycle("init");
      end
      idle();

      // LOAD with same-cycle bypass, then bus read-back.
      wr_en = 1; wr_op = 2'd0; wr_addr = 3; wr_data = 16'h1234; rd_a_addr = 3;
      #2;
      check("t2_byp_d", rd_a_data, 16'h1234);
      check("t2_byp_v", rd_a_valid, 1);
      cycle("t2");
      wr_en = 0; bus_en = 1; bus_addr = 3;
      cycle("t2b");
      check("t2_bus_d", bus_data, 16'h1234);
      check("t2_bus_v", bus_valid, 1);
      bus_en = 0;

      // ADD wraps modulo 2^WIDTH.
      write(0, 5, 16'hFFFF, "t3l");
      write(1, 5, 16'h0003, "t3a");
      rd_a_addr = 5;
      #2;
      check("t3_wrap_d", rd_a_data, 16'h0002);
      check("t3_wrap_v", rd_a_valid, 1);
      cycle("t3r");

      // INVAL drops the flag and keeps the data.
      wr_en = 1; wr_op = 2'd2; wr_addr = 3; rd_a_addr = 3;
      #2;
      check("t6_byp_v", rd_a_valid, 0);
      check("t6_byp_d", rd_a_data, 16'h1234);
      cycle("t6");
      wr_en = 0;
      #2;
      check("t6_st_v", rd_a_valid, 0);
      check("t6_st_d", rd_a_data, 16'h1234);
      cycle("t6r");

      // Clear wins over a same-cycle LOAD.
      clr = 1; rd_b_addr = 2;
      write(0, 2, 16'h00AA, "t4");
      clr = 0;
      for (int a = 0; a < D; a++) begin
         rd_a_addr = AW'(a);
         #1;
         check("t4_clr_v", rd_a_valid, 0);
         check("t4_clr_d", rd_a_data, 0);
      end
      @(posedge clk); #1;

      // Out-of-range write and read.
      write(0, 1, 16'h0F0F, "t5p");
      rd_b_addr = 7;
      wr_en = 1; wr_op = 2'd0; wr_addr = 7; wr_data = 16'h5555;
      #2;
      check("t5_rdb_d", rd_b_data, 0);
      check("t5_rdb_v", rd_b_valid, 0);
      cycle("t5");
      wr_en = 0;
      for (int a = 0; a < 8; a++) begin
         rd_a_addr = AW'(a); rd_b_addr = AW'(a); bus_en = 1; bus_addr = AW'(a);
         cycle("t5s");
      end
      idle();

      // Randomised traffic.
      for (int n = 0; n < 600; n++) begin
         clr       = ($urandom_range(0, 19) == 0);
         wr_en     = $urandom_range(0, 1);
         wr_op     = 2'($urandom_range(0, 3));
         wr_addr   = AW'($urandom_range(0, 7));
         wr_data   = ($urandom_range(0, 3) == 0) ? W'(16'hFFF0 + $urandom_range(0, 15)) : W'($urandom);
         rd_a_addr = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, 7));
         rd_b_addr = AW'($urandom_range(0, 7));
         bus_en    = $urandom_range(0, 1);
         bus_addr  = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, 7));
         cycle("rnd");
      end
      idle();

      // Reset in the middle of a LOAD and a bus read.
      write(0, 3, 16'hA5A5, "t7p");
      wr_en = 1; wr_op = 2'd0; wr_addr = 1; wr_data = 16'hBEEF;
      rd_a_addr = 1; rd_b_addr = 3; bus_en = 1; bus_addr = 3;
      cycle("t7q");
      #2;
      rst = 0;
      #1;
      check("t7_rda_d", rd_a_data, 0);
      check("t7_rda_v", rd_a_valid, 0);
      check("t7_rdb_d", rd_b_data, 0);
      check("t7_rdb_v", rd_b_valid, 0);
      check("t7_bus_d", bus_data, 0);
      check("t7_bus_v", bus_valid, 0);
      model_reset();
      idle();
      #2;
      rst = 1;
      @(posedge clk); #1;
      rd_a_addr = 1; rd_b_addr = 3; bus_en = 1; bus_addr = 1;
      cycle("t7r");
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
